// File: rtl/receiving.sv
// 16x-oversampled async serial receiver: start, 8 data bits LSB first, optional even parity, stop.
// Define RX_PARITY_EN to add the parity bit and parity_err checking.
module receiving (
  input  logic       clk,
  input  logic       reset,
  input  logic       r_enable,
  input  logic       data_in,
  input  logic       char_ack,
  output logic [7:0] data_out,
  output logic       charReceived,
  output logic       char_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic [2:0] fsm_state
);

  // The consumer side has no ready: a frame is offered by charReceived/char_valid and
  // retired by char_ack; accepting while char_valid is still high (and not acked) is an overrun.

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
  logic par_bit;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

  state_t     state;
  logic       sync_a;
  logic       s;
  logic [3:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic       rearm_wait;

  assign fsm_state = state;

`ifndef RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a       <= 1'b1;
      s            <= 1'b1;
      state        <= IDLE;
      cnt          <= 4'd0;
      idx          <= 3'd0;
      shreg        <= 8'h00;
      rearm_wait   <= 1'b0;
      data_out     <= 8'h00;
      charReceived <= 1'b0;
      char_valid   <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      sync_a       <= data_in;
      s            <= sync_a;
      charReceived <= 1'b0;

      if (char_ack) begin
        char_valid <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
`ifdef RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end

      // After a framing error the line must return high before a new start is honoured.
      if (s) rearm_wait <= 1'b0;

      if (!r_enable) begin
        state <= IDLE;
        cnt   <= 4'd0;
        idx   <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= 4'd0;
            idx <= 3'd0;
            if (!rearm_wait && !s) state <= START;
          end
          START: begin
            if (cnt == 4'd7) begin
              cnt <= 4'd0;
              idx <= 3'd0;
              state <= s ? IDLE : DATA;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          DATA: begin
            if (cnt == 4'd15) begin
              cnt        <= 4'd0;
              shreg[idx] <= s;
              if (idx == 3'd7) begin
`ifdef RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
`ifdef RX_PARITY_EN
          PARITY: begin
            if (cnt == 4'd15) begin
              cnt     <= 4'd0;
              par_bit <= s;
              state   <= STOP;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
`endif
          STOP: begin
            if (cnt == 4'd15) begin
              cnt   <= 4'd0;
              state <= IDLE;
              if (s) begin
                data_out     <= shreg;
                charReceived <= 1'b1;
                char_valid   <= 1'b1;
                if (char_valid && !char_ack) overrun <= 1'b1;
`ifdef RX_PARITY_EN
                if ((^shreg) != par_bit) parity_err <= 1'b1;
`endif
              end else begin
                frame_err  <= 1'b1;
                rearm_wait <= 1'b1;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receiving.sv
// Directed bench for receiving: a vector table of frames plus hand sequences for
// frame timing, glitches, back-to-back overrun, enable drop, mid-frame reset and parity.
module tb_receiving;
  logic       clk = 1'b0;
  logic       reset;
  logic       r_enable;
  logic       data_in;
  logic       char_ack;
  logic [7:0] data_out;
  logic       charReceived;
  logic       char_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic [2:0] fsm_state;

  int compared   = 0;
  int mismatched = 0;

`ifdef RX_PARITY_EN
  localparam int FRAME_LAT = 171;
`else
  localparam int FRAME_LAT = 155;
`endif

  receiving dut (
    .clk          (clk),
    .reset        (reset),
    .r_enable     (r_enable),
    .data_in      (data_in),
    .char_ack     (char_ack),
    .data_out     (data_out),
    .charReceived (charReceived),
    .char_valid   (char_valid),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .parity_err   (parity_err),
    .fsm_state    (fsm_state)
  );

  // clock / cycle counter / pulse monitor
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pulse_cnt      = 0;
  int last_pulse_cyc = -1;
  always @(negedge clk) begin
    if (charReceived === 1'b1) begin
      pulse_cnt      = pulse_cnt + 1;
      last_pulse_cyc = cyc;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    tick(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
    send_bit((^d) ^ par_bad);
`else
    if (par_bad) data_in = 1'b1;
`endif
    send_bit(stop);
    data_in = 1'b1;
  endtask

  task automatic do_ack();
    char_ack = 1'b1;
    tick(1);
    char_ack = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " data_out"},     32'(data_out),     32'h00);
    check({tag, " charReceived"}, 32'(charReceived), 32'h0);
    check({tag, " char_valid"},   32'(char_valid),   32'h0);
    check({tag, " frame_err"},    32'(frame_err),    32'h0);
    check({tag, " overrun"},      32'(overrun),      32'h0);
    check({tag, " parity_err"},   32'(parity_err),   32'h0);
    check({tag, " fsm_state"},    32'(fsm_state),    32'h0);
  endtask

  typedef struct {
    logic       ack;
    logic [7:0] din;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_fe;
    logic       exp_ov;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[7];
  int   p0;
  int   start_cyc;
  logic [7:0] rd;

  initial begin
    // ack, data, stop, exp data, valid, frame_err, overrun, pulses (state carries between rows)
    vecs[0] = '{1'b1, 8'h41, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 8'h41, 1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{1'b1, 8'h12, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1};
    vecs[3] = '{1'b0, 8'h34, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 1};
    vecs[4] = '{1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    vecs[6] = '{1'b0, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0};

    reset    = 1'b0;
    r_enable = 1'b1;
    data_in  = 1'b1;
    char_ack = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    tick(5);

    // frame latency: start driven just after edge T, pulse expected in the cycle after edge T+155
    do_ack();
    p0        = pulse_cnt;
    start_cyc = cyc;
    send_frame(8'h41, 1'b1, 1'b0);
    tick(10);
    check("lat pulses",     32'(pulse_cnt - p0),               32'd1);
    check("lat pulse_edge", 32'(last_pulse_cyc - start_cyc),   32'(FRAME_LAT));
    check("lat data_out",   32'(data_out),                     32'h41);
    check("lat char_valid", 32'(char_valid),                   32'h1);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].ack) do_ack();
      p0 = pulse_cnt;
      send_frame(vecs[v].din, vecs[v].stop, 1'b0);
      tick(8);
      check($sformatf("vec%0d data_out", v),   32'(data_out),         32'(vecs[v].exp_data));
      check($sformatf("vec%0d char_valid", v), 32'(char_valid),       32'(vecs[v].exp_valid));
      check($sformatf("vec%0d frame_err", v),  32'(frame_err),        32'(vecs[v].exp_fe));
      check($sformatf("vec%0d overrun", v),    32'(overrun),          32'(vecs[v].exp_ov));
      check($sformatf("vec%0d pulses", v),     32'(pulse_cnt - p0),   32'(vecs[v].exp_pulses));
      check($sformatf("vec%0d parity_err", v), 32'(parity_err),       32'h0);
    end

    // short low glitches on an idle line are rejected without flags
    for (int len = 1; len <= 7; len++) begin
      do_ack();
      p0 = pulse_cnt;
      data_in = 1'b0;
      tick(len);
      data_in = 1'b1;
      tick(20);
      check($sformatf("glitch%0d pulses", len), 32'(pulse_cnt - p0), 32'd0);
      check($sformatf("glitch%0d state", len),  32'(fsm_state),      32'h0);
      check($sformatf("glitch%0d flags", len),
            32'({char_valid, frame_err, overrun, parity_err}), 32'h0);
    end

    // back-to-back frames without ack
    do_ack();
    p0 = pulse_cnt;
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    tick(8);
    check("b2b pulses",     32'(pulse_cnt - p0), 32'd2);
    check("b2b data_out",   32'(data_out),       32'h34);
    check("b2b overrun",    32'(overrun),        32'h1);
    check("b2b char_valid", 32'(char_valid),     32'h1);
    do_ack();
    check("b2b ack valid",   32'(char_valid), 32'h0);
    check("b2b ack overrun", 32'(overrun),    32'h0);

    // enable dropped mid-frame
    p0 = pulse_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    r_enable = 1'b0;
    tick(1);
    check("ren state", 32'(fsm_state), 32'h0);
    data_in = 1'b1;
    tick(200);
    r_enable = 1'b1;
    tick(5);
    check("ren pulses",   32'(pulse_cnt - p0), 32'd0);
    check("ren data_out", 32'(data_out),       32'h34);
    check("ren flags",    32'({char_valid, frame_err, overrun, parity_err}), 32'h0);

    // reset during data bit 4, then a clean frame
    p0 = pulse_cnt;
    rd = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rd[i]);
    data_in = rd[4];
    tick(8);
    reset = 1'b0;
    #2;
    check_reset_outputs("midrst");
    tick(1);
    data_in = 1'b1;
    reset = 1'b1;
    tick(200);
    check("midrst pulses", 32'(pulse_cnt - p0), 32'd0);
    p0 = pulse_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    tick(8);
    check("post data_out",   32'(data_out),       32'h55);
    check("post pulses",     32'(pulse_cnt - p0), 32'd1);
    check("post char_valid", 32'(char_valid),     32'h1);

`ifdef RX_PARITY_EN
    // wrong parity still delivers the character
    do_ack();
    p0 = pulse_cnt;
    send_frame(8'h03, 1'b1, 1'b1);
    tick(8);
    check("par parity_err", 32'(parity_err),     32'h1);
    check("par data_out",   32'(data_out),       32'h03);
    check("par pulses",     32'(pulse_cnt - p0), 32'd1);
    do_ack();
    check("par ack clears", 32'(parity_err),     32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/receiving.md
RECEIVING -- requirements
Module: receiving

Interface
REQ-001 Ports: clk input 1, 16x-oversample bit clock, all state on rising edge.
REQ-002 Ports: reset input 1, asynchronous, active-low; clears all state.
REQ-003 Ports: r_enable input 1, receiver enable; low holds the FSM in IDLE.
REQ-004 Ports: data_in input 1, asynchronous serial line, idle high.
REQ-005 Ports: char_ack input 1, consumer acknowledge; clears char_valid.
REQ-006 Ports: data_out output 8, last received character, held until next good frame.
REQ-007 Ports: charReceived output 1, one-cycle pulse per accepted frame.
REQ-008 Ports: char_valid output 1, high from accepted frame until char_ack.
REQ-009 Ports: frame_err output 1, sticky, stop bit sampled low.
REQ-010 Ports: overrun output 1, sticky, frame accepted while char_valid high.
REQ-011 Ports: parity_err output 1, sticky; meaningful only with RX_PARITY_EN.

Function
REQ-012 data_in SHALL pass a two-flop synchronizer; s denotes its output; data_in changing at edge T appears on s at edge T+2.
REQ-013 Frame: start 0, 8 data bits LSB first, optional parity, stop 1; 16 clk per bit.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: r_enable high and s low -> START, sample counter cleared to 0.
REQ-016 START: counter 0..7; at count 7 s low -> DATA with bit index 0 and counter 0; s high -> IDLE (glitch rejection, no flags).
REQ-017 DATA: counter 0..15; at count 15 shift s into bit index position, then index increments; after index 7 -> PARITY if enabled, else STOP.
REQ-018 PARITY: at count 15 sample parity bit -> STOP.
REQ-019 STOP: at count 15 sample s; s high -> accept frame, return IDLE; s low -> set frame_err, discard data, return IDLE and wait for s high before rearming.
REQ-020 Accept: data_out loaded and charReceived pulsed on the cycle after the stop sample; char_valid set the same cycle.
REQ-021 Accept while char_valid high: set overrun, data_out SHALL still be overwritten.
REQ-022 char_ack and accept in same cycle: char_valid stays high, overrun not set.
REQ-023 r_enable dropping mid-frame: FSM returns to IDLE next cycle, partial data discarded, no flag change.
REQ-024 Sticky flags clear only on reset or on char_ack.

Reset
REQ-025 reset low asynchronously: FSM IDLE, counters 0, synchronizer flops 1, data_out 0x00, charReceived/char_valid/frame_err/overrun/parity_err 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulse after release.

Configuration
REQ-027 Macro RX_PARITY_EN defined: PARITY state present, even parity over 8 data bits; mismatch sets parity_err but frame still accepted.
REQ-028 RX_PARITY_EN undefined: PARITY state removed, 10-bit frame, parity_err tied 0.

Verification
REQ-029 Frame 0x41 (start falls at edge T, no parity) -> charReceived pulse at edge T+155 only, data_out=0x41, char_valid=1.
REQ-030 1-to-7-cycle low glitch on idle line -> no pulse, FSM back in IDLE, all flags 0.
REQ-031 Frame 0xA5 with stop bit 0 -> frame_err=1, no charReceived, data_out unchanged.
REQ-032 Two back-to-back frames 0x12, 0x34 without char_ack -> data_out=0x34, overrun=1; char_ack then clears char_valid and overrun.
REQ-033 Reset pulsed low during data bit 4 -> all outputs reset value, next clean frame 0x55 received correctly.
REQ-034 RX_PARITY_EN defined, frame 0x03 with parity bit 1 -> parity_err=1, data_out=0x03, charReceived pulses.
